// File: rtl/skeleton_ram_bist.sv
// rtl/skeleton_ram_bist.sv - RAM with direct word access and an address-XOR-seed pattern self-test
module skeleton_ram_bist #(
    parameter int BITWIDTH_IN   = 12,
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_HEAD = 26,
    parameter int BITWIDTH_ADR  = 6,
    parameter int BITWIDTH_BANK = 1
) (
    input  logic                                 CLK_SYS,
    input  logic                                 RSTN,
    input  logic                                 EN,
    input  logic                                 TRGG_START_CALC,
    input  logic                                 MODE,
    input  logic                                 RnW,
    input  logic [BITWIDTH_BANK+BITWIDTH_ADR-1:0] ADR,
    input  logic [BITWIDTH_SYS-1:0]              DATA_IN,
    output logic [BITWIDTH_SYS-1:0]              DATA_OUT,
    output logic [BITWIDTH_HEAD-1:0]             DATA_HEAD,
    output logic                                 RDY
);
    localparam int AW = BITWIDTH_BANK + BITWIDTH_ADR;
    localparam int N  = 2**AW;
    localparam int PW = (BITWIDTH_IN < AW) ? BITWIDTH_IN : AW;
    localparam logic [AW-1:0]           LAST_ADR = '1;
    localparam logic [AW-1:0]           ADR_ONE  = 1;
    localparam logic [BITWIDTH_SYS-1:0] ERR_MAX  = '1;
    localparam logic [BITWIDTH_SYS-1:0] ERR_ONE  = 1;

    typedef enum logic [2:0] {IDLE, ACC, BW, BR, BFIN} state_t;

    state_t                  state;
    logic [BITWIDTH_IN-1:0]  mem [N];
    logic [BITWIDTH_IN-1:0]  rd_data;
    logic [BITWIDTH_IN-1:0]  din_q;
    logic [BITWIDTH_IN-1:0]  wr_data;
    logic [AW-1:0]           adr_q;
    logic [AW-1:0]           addr_cnt;
    logic [AW-1:0]           cmp_adr;
    logic [AW-1:0]           wr_adr;
    logic [AW-1:0]           rd_adr;
    logic                    rnw_q;
    logic                    cmp_valid;
    logic                    wr_en;
    logic                    mismatch;
    logic [BITWIDTH_SYS-1:0] err_cnt;
    logic [BITWIDTH_SYS-1:0] err_next;
    logic [BITWIDTH_SYS-1:0] rd_aligned;
    logic                    unused_data_in;

    // Expected BIST word: address fitted to the word width, XORed with the seed
    function automatic logic [BITWIDTH_IN-1:0] pattern(input logic [AW-1:0] a,
                                                       input logic [BITWIDTH_IN-1:0] s);
        logic [BITWIDTH_IN-1:0] p;
        p = '0;
        for (int i = 0; i < PW; i++) begin
            p[i] = a[i];
        end
        return p ^ s;
    endfunction

    assign DATA_HEAD = BITWIDTH_HEAD'({4'd5, 2'd0, 4'(BITWIDTH_BANK), 6'(BITWIDTH_ADR),
                                       5'(BITWIDTH_IN), 5'(BITWIDTH_IN)});

    // Only the top BITWIDTH_IN bits of DATA_IN carry data or seed
    assign unused_data_in = ^DATA_IN;

    // RAM port muxing: reads follow ADR while idle so a direct read is issued on the trigger edge
    always_comb begin
        wr_en      = ((state == ACC) && !rnw_q) || (state == BW);
        wr_adr     = (state == BW) ? addr_cnt : adr_q;
        wr_data    = (state == BW) ? pattern(addr_cnt, din_q) : din_q;
        rd_adr     = (state == BR) ? addr_cnt : ADR;
        mismatch   = cmp_valid && (rd_data != pattern(cmp_adr, din_q));
        err_next   = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_ONE : err_cnt;
        rd_aligned = '0;
        rd_aligned[BITWIDTH_SYS-1 -: BITWIDTH_IN] = rd_data;
    end

    // Storage array with registered read; contents survive reset and freeze with EN
    always_ff @(posedge CLK_SYS) begin
        if (EN) begin
            if (wr_en) begin
                mem[wr_adr] <= wr_data;
            end
            rd_data <= mem[rd_adr];
        end
    end

    // Control FSM with compare pipeline, error counter and registered outputs
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            cmp_adr   <= '0;
            cmp_valid <= 1'b0;
            err_cnt   <= '0;
            adr_q     <= '0;
            din_q     <= '0;
            rnw_q     <= 1'b0;
            RDY       <= 1'b1;
            DATA_OUT  <= '0;
        end else if (EN) begin
            cmp_valid <= 1'b0;
            if (cmp_valid) begin
                err_cnt <= err_next;
            end
            case (state)
                IDLE: begin
                    if (TRGG_START_CALC) begin
                        adr_q    <= ADR;
                        rnw_q    <= RnW;
                        din_q    <= DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN];
                        addr_cnt <= '0;
                        RDY      <= 1'b0;
                        if (!MODE) begin
                            state <= ACC;
                        end else begin
                            err_cnt <= '0;
                            state   <= RnW ? BR : BW;
                        end
                    end
                end
                ACC: begin
                    if (rnw_q) begin
                        DATA_OUT <= rd_aligned;
                    end
                    RDY   <= 1'b1;
                    state <= IDLE;
                end
                BW: begin
                    addr_cnt <= addr_cnt + ADR_ONE;
                    if (addr_cnt == LAST_ADR) begin
                        state <= BR;
                    end
                end
                BR: begin
                    cmp_valid <= 1'b1;
                    cmp_adr   <= addr_cnt;
                    addr_cnt  <= addr_cnt + ADR_ONE;
                    if (addr_cnt == LAST_ADR) begin
                        state <= BFIN;
                    end
                end
                BFIN: begin
                    DATA_OUT <= err_next;
                    RDY      <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_skeleton_ram_bist.sv
// tb/tb_skeleton_ram_bist.sv - Randomized model-checked bench for skeleton_ram_bist
module tb_skeleton_ram_bist;
    localparam int N = 128;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en = 1'b0;
    logic        trg = 1'b0;
    logic        mode = 1'b0;
    logic        rnw = 1'b0;
    logic [6:0]  adr = '0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic [25:0] head;
    logic        rdy;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    bit started = 0;

    skeleton_ram_bist dut (
        .CLK_SYS(clk), .RSTN(rstn), .EN(en), .TRGG_START_CALC(trg), .MODE(mode),
        .RnW(rnw), .ADR(adr), .DATA_IN(din), .DATA_OUT(dout), .DATA_HEAD(head), .RDY(rdy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: operation outcome and duration in enabled cycles, RAM as a plain array
    logic [11:0] ref_mem [N];
    bit          m_busy = 0;
    int          m_kind = 0;
    int          m_e = 0;
    int          m_len = 0;
    logic [6:0]  m_adr = '0;
    logic [11:0] m_din = '0;
    bit          exp_rdy = 1;
    logic [15:0] exp_dout = '0;

    function automatic logic [11:0] pat(input int a, input logic [11:0] s);
        return 12'(a) ^ s;
    endfunction

    function automatic logic [15:0] bist_errors(input logic [11:0] s);
        int c = 0;
        for (int i = 0; i < N; i++) begin
            if (ref_mem[i] != pat(i, s)) c++;
        end
        return (c > 65535) ? 16'hFFFF : 16'(c);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy   = 0;
            exp_rdy  = 1;
            exp_dout = '0;
        end else if (en) begin
            if (m_busy) begin
                m_e++;
                if (m_kind == 2 && m_e <= N) ref_mem[m_e-1] = pat(m_e - 1, m_din);
                if (m_e == m_len) begin
                    m_busy  = 0;
                    exp_rdy = 1;
                    case (m_kind)
                        0: ref_mem[m_adr] = m_din;
                        1: exp_dout = {ref_mem[m_adr], 4'h0};
                        default: exp_dout = bist_errors(m_din);
                    endcase
                end
            end else if (trg) begin
                m_busy  = 1;
                exp_rdy = 0;
                m_e     = 0;
                m_adr   = adr;
                m_din   = din[15:4];
                if (!mode) begin
                    m_kind = rnw ? 1 : 0;
                    m_len  = 1;
                end else if (!rnw) begin
                    m_kind = 2;
                    m_len  = 2 * N + 1;
                end else begin
                    m_kind = 3;
                    m_len  = N + 1;
                end
            end
        end
    end

    // Every cycle: outputs against the model, header against its fixed value
    always @(negedge clk) begin
        if (started) begin
            check("rdy", 32'(rdy), 32'(exp_rdy));
            check("data_out", 32'(dout), 32'(exp_dout));
            check("data_head", 32'(head), 32'h141198C);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input int t, input bit noise, output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rdy) begin
                lat = cyc - t;
                break;
            end
            if (noise) begin
                en   = ($urandom_range(0, 4) != 0);
                trg  = ($urandom_range(0, 7) == 0);
                mode = 1'($urandom);
                rnw  = 1'($urandom);
                adr  = 7'($urandom);
                din  = 16'($urandom);
            end
        end
        trg = 0;
        en  = 1;
        if (lat < 0) check("rdy_timeout", 0, 1);
    endtask

    task automatic run_op(input bit m, input bit r, input logic [6:0] a, input logic [15:0] d,
                          input bit noise, output int lat);
        int t;
        mode = m; rnw = r; adr = a; din = d; en = 1; trg = 1;
        t = cyc;
        tick();
        trg = 0;
        wait_rdy(t, noise, lat);
    endtask

    initial begin
        int lat;
        int t;
        #1 rstn = 0;
        started = 1;
        @(negedge clk);
        check("reset_rdy", 32'(rdy), 1);
        check("reset_dout", 32'(dout), 32'h0000);
        check("reset_head", 32'(head), 32'h141198C);
        tick();
        rstn = 1;
        en   = 1;

        // Direct write then read back
        run_op(0, 0, 7'h45, 16'hABC0, 0, lat);
        check("dw_latency", 32'(lat), 2);
        run_op(0, 1, 7'h45, 16'h0000, 0, lat);
        check("dr_latency", 32'(lat), 2);
        check("dr_data", 32'(dout), 32'hABC0);

        // Full write+check with seed 0x5A5
        run_op(1, 0, 7'h00, 16'h5A50, 0, lat);
        check("bist_wc_latency", 32'(lat), 258);
        check("bist_wc_errors", 32'(dout), 0);

        // Two corrupted words found by check-only
        run_op(0, 0, 7'd3, 16'h0000, 0, lat);
        run_op(0, 0, 7'd70, 16'h0000, 0, lat);
        run_op(1, 1, 7'h00, 16'h5A50, 0, lat);
        check("bist_co_latency", 32'(lat), 130);
        check("bist_co_errors", 32'(dout), 2);

        // Stall during BW plus an ignored trigger while busy
        mode = 1; rnw = 0; din = 16'h5A50; trg = 1;
        t = cyc;
        tick();
        trg = 0;
        repeat (20) tick();
        en = 0;
        repeat (10) tick();
        en = 1;
        tick();
        mode = 0; rnw = 1; adr = 7'd5; trg = 1;
        tick();
        trg = 0;
        wait_rdy(t, 0, lat);
        check("bist_stall_latency", 32'(lat), 268);
        check("bist_stall_errors", 32'(dout), 0);

        // Reset in the middle of a write+check, then read immediately after release
        mode = 1; rnw = 0; din = 16'h1230; trg = 1;
        t = cyc;
        tick();
        trg = 0;
        repeat (49) tick();
        rstn = 0;
        @(negedge clk);
        check("midreset_rdy", 32'(rdy), 1);
        check("midreset_dout", 32'(dout), 0);
        tick();
        rstn = 1;
        run_op(0, 1, 7'd10, 16'h0000, 0, lat);
        check("post_reset_rd_lat", 32'(lat), 2);
        check("post_reset_rd10", 32'(dout), 32'h1290);
        run_op(0, 1, 7'd100, 16'h0000, 0, lat);
        check("post_reset_rd100", 32'(dout), 32'h5C10);

        // Randomized operations with EN stalls and spurious triggers
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                en = 0; trg = 1; mode = 1'($urandom); rnw = 1'($urandom);
                tick();
                trg = 0; en = 1;
            end
            run_op(($urandom_range(0, 4) == 0), 1'($urandom), 7'($urandom), 16'($urandom), 1, lat);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/skeleton_ram_bist.md
SKELETON_RAM_BIST -- requirements
Module: skeleton_ram_bist

Interface
REQ-001 SHALL have parameter BITWIDTH_IN, default 12: stored RAM word width.
REQ-002 SHALL have parameter BITWIDTH_SYS, default 16: device data bus width, at least BITWIDTH_IN.
REQ-003 SHALL have parameter BITWIDTH_HEAD, default 26: metadata width.
REQ-004 SHALL have parameter BITWIDTH_ADR, default 6: address width per bank.
REQ-005 SHALL have parameter BITWIDTH_BANK, default 1: bank-select width; NUM_BANKS = 2**BITWIDTH_BANK and N = 2**(BITWIDTH_BANK+BITWIDTH_ADR) words in total.
REQ-006 SHALL have port CLK_SYS  in  1: the single system clock; all logic is rising-edge.
REQ-007 SHALL have port RSTN  in  1: asynchronous, active-low reset.
REQ-008 SHALL have port EN  in  1: global enable; while low the block stalls.
REQ-009 SHALL have port TRGG_START_CALC  in  1: single-cycle start of an operation.
REQ-010 SHALL have port MODE  in  1: 0 = direct access, 1 = BIST.
REQ-011 SHALL have port RnW  in  1: direct mode 1 = read, 0 = write; BIST mode 0 = write+check, 1 = check-only.
REQ-012 SHALL have port ADR  in  BITWIDTH_BANK+BITWIDTH_ADR: {bank, word}.
REQ-013 SHALL have port DATA_IN  in  BITWIDTH_SYS: write data, MSB-aligned; in BIST mode, the seed.
REQ-014 SHALL have port DATA_OUT  out  BITWIDTH_SYS: read data or error count.
REQ-015 SHALL have port DATA_HEAD  out  BITWIDTH_HEAD: constant {4'd5, 2'd0, BITWIDTH_BANK[3:0], BITWIDTH_ADR[5:0], BITWIDTH_IN[4:0], BITWIDTH_IN[4:0]}.
REQ-016 SHALL have port RDY  out  1: 1 = idle and result valid, 0 = busy.

Function
REQ-017 SHALL contain an internal RAM of N x BITWIDTH_IN words with a registered synchronous read; RAM contents are not cleared by reset.
REQ-018 SHALL use the states IDLE, ACC, BW, BR, BFIN: IDLE to ACC on trigger with MODE=0; IDLE to BW on trigger with MODE=1, RnW=0; IDLE to BR on trigger with MODE=1, RnW=1; BW to BR after address N-1; BR to BFIN after the last read is issued; ACC and BFIN return to IDLE.
REQ-019 SHALL accept a trigger only in IDLE with EN=1, latching ADR, RnW, MODE and DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN]; a trigger in any other state is ignored.
REQ-020 SHALL, on a direct write triggered at cycle T, write the RAM at T+1 with RDY=0 during T+1 and RDY=1 from T+2, leaving DATA_OUT unchanged.
REQ-021 SHALL, on a direct read triggered at cycle T, set DATA_OUT = {word, BITWIDTH_SYS-BITWIDTH_IN zeros} with RDY=1 at T+2, and hold DATA_OUT until the next result.
REQ-022 SHALL use the BIST pattern for address a = (a zero-extended or truncated to BITWIDTH_IN) XOR seed.
REQ-023 SHALL, in BW, write the pattern to addresses 0..N-1 ascending, one address per enabled cycle.
REQ-024 SHALL, in BR, read addresses 0..N-1 ascending, compare each word one cycle after it is issued, and increment the error counter on mismatch.
REQ-025 SHALL saturate the error counter at 2**BITWIDTH_SYS-1 and clear it at each BIST start.
REQ-026 SHALL, for an uninterrupted BIST triggered at T, set RDY=1 and DATA_OUT = error count at T+2N+2 for write+check and at T+N+2 for check-only; RDY=0 in between.
REQ-027 SHALL, while EN=0, freeze state, addresses, RAM access, the compare pipeline and the outputs; every latency above extends by exactly the number of EN=0 cycles.
REQ-028 SHALL, on a trigger and the completion of an operation in the same cycle, ignore the trigger.

Reset
REQ-029 SHALL, when RSTN=0 at any time, including mid-operation, immediately enter IDLE with RDY=1, DATA_OUT=0 and the error counter and address counters at 0.
REQ-030 SHALL keep DATA_HEAD constant and independent of reset.
REQ-031 SHALL accept a trigger in the first cycle after RSTN rises.

Verification (defaults: N=128)
REQ-032 SHALL cover: reset asserted -> RDY=1, DATA_OUT=0x0000, DATA_HEAD=0x141198C.
REQ-033 SHALL cover: direct write DATA_IN=0xABC0 at ADR=0x45, then direct read of 0x45 triggered at T -> RDY=0 at T+1; DATA_OUT=0xABC0 and RDY=1 at T+2.
REQ-034 SHALL cover: BIST write+check with seed DATA_IN=0x5A50 triggered at T -> RDY=0 from T+1 to T+257; RDY=1 and DATA_OUT=0x0000 at T+258.
REQ-035 SHALL cover: after REQ-034, direct write 0x0000 to ADR 3 and ADR 70, then check-only with seed 0x5A50 triggered at T -> DATA_OUT=0x0002 at T+130.
REQ-036 SHALL cover: EN=0 for 10 cycles during BW, plus a trigger pulsed while busy -> completion at T+268, DATA_OUT=0x0000, the extra trigger has no effect.
REQ-037 SHALL cover: RSTN low at T+50 of a BIST -> RDY=1 and DATA_OUT=0 in the same cycle; a new direct read after release returns the RAM content.
